// File: rtl/systolic_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl_if
// Description : Signal bundle between the systolic-array sequencer and its
//               neighbours (command source, operand feeder, PE array,
//               result collector).
//               master : sequencer side (drives pacing and readout signals)
//               slave  : environment side (drives start/k_len/out_ready)
// Ports       : none (signal container only)
//               start/k_len   command strobe and inner dimension K
//               out_ready     result collector accepts current row
//               busy, array_clr, feed_valid, feed_cnt, lane_en,
//               out_valid, out_row, done, err   sequencer outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_seq_ctrl_if #(
    parameter int ARRAY_N = 4,
    parameter int K_MAX   = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int CW = $clog2(K_MAX + 2 * ARRAY_N);
    localparam int RW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

    logic               start;
    logic [KW-1:0]      k_len;
    logic               out_ready;
    logic               busy;
    logic               array_clr;
    logic               feed_valid;
    logic [CW-1:0]      feed_cnt;
    logic [ARRAY_N-1:0] lane_en;
    logic               out_valid;
    logic [RW-1:0]      out_row;
    logic               done;
    logic               err;

    modport master (
        input  start, k_len, out_ready,
        output busy, array_clr, feed_valid, feed_cnt, lane_en,
               out_valid, out_row, done, err
    );

    modport slave (
        output start, k_len, out_ready,
        input  busy, array_clr, feed_valid, feed_cnt, lane_en,
               out_valid, out_row, done, err
    );
endinterface

`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl
// Description : Sequencer for an ARRAY_N x ARRAY_N output-accumulating
//               systolic MAC array. On start it clears the accumulators,
//               paces diagonally skewed operand injection, waits for the
//               wavefront to drain and then presents each array row to the
//               result collector over a valid/ready handshake.
// Ports       : clk    rising-edge clock
//               reset  synchronous, active-high reset
//               bus    systolic_seq_ctrl_if.master
//                      in : start, k_len, out_ready
//                      out: busy, array_clr, feed_valid, feed_cnt, lane_en,
//                           out_valid, out_row, done, err
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int ARRAY_N = 4,
    parameter int K_MAX   = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    systolic_seq_ctrl_if.master bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int CW = $clog2(K_MAX + 2 * ARRAY_N);
    localparam int RW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_feed  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_out   = 3'd4;

    localparam logic [KW-1:0] c_k_max      = KW'(K_MAX);
    // Modular: for ARRAY_N == 1 this is all-ones and K + (N-2) still
    // evaluates to K-1 in CW bits.
    localparam logic [CW-1:0] c_n_minus_2  = CW'(ARRAY_N - 2);
    localparam logic [CW-1:0] c_drain_last = CW'((ARRAY_N > 1) ? ARRAY_N - 2 : 0);
    localparam logic [RW-1:0] c_last_row   = RW'(ARRAY_N - 1);
    localparam bit            c_has_drain  = (ARRAY_N > 1);

    // Control state
    logic [2:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [KW-1:0]      r_k;
    logic [RW-1:0]      r_row;

    // Registered outputs
    logic               r_busy;
    logic               r_array_clr;
    logic               r_feed_valid;
    logic [CW-1:0]      r_feed_cnt;
    logic [ARRAY_N-1:0] r_lane_en;
    logic               r_out_valid;
    logic [RW-1:0]      r_out_row;
    logic               r_done;
    logic               r_err;

    // Next-state values
    logic [2:0]         w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [KW-1:0]      w_k_nxt;
    logic [RW-1:0]      w_row_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_k_ok;
    logic [CW-1:0]      w_feed_last;
    logic               w_in_feed;
    logic               w_in_out;
    logic [ARRAY_N-1:0] w_lane_nxt;

    assign w_k_ok      = (bus.k_len != '0) && (bus.k_len <= c_k_max);
    assign w_feed_last = CW'(r_k) + c_n_minus_2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_row_nxt   = r_row;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    if (w_k_ok) begin
                        w_state_nxt = c_st_clear;
                        w_k_nxt     = bus.k_len;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            c_st_clear: begin
                w_state_nxt = c_st_feed;
                w_cnt_nxt   = '0;
            end
            c_st_feed: begin
                if (r_cnt == w_feed_last) begin
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = c_has_drain ? c_st_drain : c_st_out;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            c_st_drain: begin
                // Last product lands in PE(N-1,N-1) on the final drain cycle.
                if (r_cnt == c_drain_last) begin
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = c_st_out;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            c_st_out: begin
                // out_valid is always high in this state, so ready alone
                // marks acceptance of the current row.
                if (bus.out_ready) begin
                    if (r_row == c_last_row) begin
                        w_state_nxt = c_st_idle;
                        w_row_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_row_nxt = r_row + RW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_in_feed = (w_state_nxt == c_st_feed);
    assign w_in_out  = (w_state_nxt == c_st_out);

    // Lane i carries element k = t - i, valid for i <= t < i + K.
    for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_lane
        localparam logic [CW-1:0] c_idx = CW'(gi);
        assign w_lane_nxt[gi] = w_in_feed
                              && (w_cnt_nxt >= c_idx)
                              && (w_cnt_nxt < (c_idx + CW'(w_k_nxt)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_k          <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_array_clr  <= 1'b0;
            r_feed_valid <= 1'b0;
            r_feed_cnt   <= '0;
            r_lane_en    <= '0;
            r_out_valid  <= 1'b0;
            r_out_row    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_k          <= w_k_nxt;
            r_row        <= w_row_nxt;
            r_busy       <= (w_state_nxt != c_st_idle);
            r_array_clr  <= (w_state_nxt == c_st_clear);
            r_feed_valid <= w_in_feed;
            r_feed_cnt   <= w_in_feed ? w_cnt_nxt : '0;
            r_lane_en    <= w_lane_nxt;
            r_out_valid  <= w_in_out;
            r_out_row    <= w_in_out ? w_row_nxt : '0;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.array_clr  = r_array_clr;
    assign bus.feed_valid = r_feed_valid;
    assign bus.feed_cnt   = r_feed_cnt;
    assign bus.lane_en    = r_lane_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_row    = r_out_row;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

`default_nettype wire

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the N×N systolic MAC array (weight-stationary-free, output-accumulating PEs).
- On a start command it clears all PE accumulators and paces operand injection with per-lane diagonal skew.
- It waits for the wavefront to drain, then hands the accumulated rows to the result collector over a valid/ready handshake.
- Sits between the operand buffers/feeder and the array plus result path.

Parameters:
ARRAY_N, 4, array dimension (rows = columns = lanes)
K_MAX, 16, maximum inner (reduction) dimension accepted
KW, $clog2(K_MAX+1), width of k_len
CW, $clog2(K_MAX+2*ARRAY_N), width of feed_cnt / internal cycle counter
RW, $clog2(ARRAY_N) (min 1), width of out_row

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
k_len  in  KW  inner dimension K, captured with start
out_ready  in  1  result collector accepts the current row
busy  out  1  high in every state except IDLE
array_clr  out  1  clears all PE accumulators (one cycle)
feed_valid  out  1  feeder must present operands this cycle
feed_cnt  out  CW  feed cycle index t; lane i reads element k = t−i
lane_en  out  ARRAY_N  lane i drives real data when set, zero otherwise
out_valid  out  1  out_row's accumulated results are presented
out_row  out  RW  array row selected for readout
done  out  1  one-cycle pulse when the last row is accepted
err  out  1  one-cycle pulse: start with k_len==0 or k_len>K_MAX

Behaviour:
- Reset (synchronous): state=IDLE, counters=0. All outputs are 0, including feed_cnt, lane_en and out_row.
- FSM states: IDLE → CLEAR → FEED → DRAIN → OUT → IDLE. All outputs are registered.
- IDLE
  - start with a valid k_len: capture K; next cycle is CLEAR.
  - start with an invalid k_len: pulse err next cycle; stay IDLE.
- CLEAR: exactly 1 cycle; array_clr=1, busy=1. Next state is FEED with t=0.
- FEED: K+N−1 cycles, t = 0..K+N−2.
  - feed_valid=1, feed_cnt=t.
  - lane_en[i] = (i ≤ t < i+K).
  - After t = K+N−2, next state is DRAIN.
- DRAIN: exactly N−1 cycles. feed_valid=0, lane_en=0.
  - The last product reaches PE(N−1,N−1) at t = K−1+2(N−1) and is registered at the end of that cycle.
  - DRAIN ends after that cycle; next state is OUT.
- OUT: out_valid=1, out_row starts at 0.
  - Row advances only on out_valid & out_ready.
  - While out_ready=0, out_valid and out_row hold (no drop, no skip).
  - Acceptance of row N−1 → done=1 for one cycle (the cycle after acceptance) and return to IDLE.
- start is ignored whenever busy=1; no queuing.
- reset asserted in any state: abort next edge to IDLE with all outputs 0. The array content is then undefined; the next job's CLEAR resets it.
- Total latency, start edge to first out_valid: 1 (CLEAR) + (K+N−1) + (N−1) cycles.
- Boundaries:
  - K=1: lane_en is one-hot walking, bit i set at t=i.
  - K=K_MAX: counter must not wrap; CW is sized for this.
  - N=1 (RW=1): DRAIN is 0 cycles and goes directly FEED→OUT.

Test Plan:
- N=4, K=3, out_ready=1, start at cycle 0:
  - array_clr at cycle 1.
  - FEED cycles 2–7 with lane_en 0001,0011,0111,1110,1100,1000.
  - DRAIN cycles 8–10; out_valid cycles 11–14 with rows 0..3; done at cycle 15.
- Backpressure, N=4, K=2: out_ready low 3 cycles while row 1 is presented → out_row holds at 1 and out_valid stays high. Rows 2 and 3 follow once out_ready returns; done pulses exactly once.
- Error cases:
  - start with k_len=0 → err pulse one cycle later; busy stays 0; no array_clr.
  - start with k_len=K_MAX+1 → same response.
- Ignored start: start re-asserted during FEED with a different k_len → no effect. Lane pattern and cycle counts match the original K.
- Reset mid-FEED (t=2): all outputs 0 at the next edge, state IDLE. A following start with K=1 runs a full clean sequence: walking one-hot lane_en, done after 4 rows.
- End to end with the PE array: K=K_MAX=16 with all-ones operands → feed_cnt reaches 18 with no wrap, and every PE result equals 16.
